lutram_bist: RTL and testbench



---
 rtl/lutram_test_pkg.sv | 22 ++
 rtl/lutram_bist_if.sv | 28 ++
 rtl/lutram_dp_array.sv | 30 +++
 rtl/lutram_bist.sv | 108 ++++++++++
 tb/tb_lutram_bist.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/lutram_test_pkg.sv
// lutram_test_pkg: shared BIST state encoding, pattern selectors and the pat() generator.
// pat() returns a 64-bit word; callers truncate it to their data width (D_WIDTH <= 64).
package lutram_test_pkg;
   localparam int PAT_W = 64;
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      VERIFY0 = 3'd2,
      WRITE   = 3'd3,
      READ    = 3'd4,
      DONE    = 3'd5
   } state_t;
   localparam logic [1:0] PAT_PARITY  = 2'd0;
   localparam logic [1:0] PAT_NPARITY = 2'd1;
   localparam logic [1:0] PAT_ONES    = 2'd2;
   localparam logic [1:0] PAT_ADDR    = 2'd3;
   function automatic logic [PAT_W-1:0] pat(input logic [1:0] m, input logic [PAT_W-1:0] a);
      return m == PAT_PARITY  ? {PAT_W{a[0]}} :
             m == PAT_NPARITY ? {PAT_W{~a[0]}} :
             m == PAT_ADDR    ? a : '1;
   endfunction
endpackage

// File: rtl/lutram_bist_if.sv
// lutram_bist_if: control/status bundle of lutram_bist.
// fault_inj is present only when LUTRAM_BIST_FAULT_INJECT_EN is defined.
interface lutram_bist_if #(
   parameter int A_WIDTH   = 5,
   parameter int ERR_WIDTH = A_WIDTH + 2
);
   logic                 start;
   logic [1:0]           mode;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [ERR_WIDTH-1:0] err_count;
   logic                 first_err_valid;
   logic [A_WIDTH-1:0]   first_err_addr;
   logic                 first_err_port;
`ifdef LUTRAM_BIST_FAULT_INJECT_EN
   logic                 fault_inj;
   modport master (output start, mode, fault_inj,
                   input  busy, done, pass, err_count, first_err_valid, first_err_addr, first_err_port);
   modport slave  (input  start, mode, fault_inj,
                   output busy, done, pass, err_count, first_err_valid, first_err_addr, first_err_port);
`else
   modport master (output start, mode,
                   input  busy, done, pass, err_count, first_err_valid, first_err_addr, first_err_port);
   modport slave  (input  start, mode,
                   output busy, done, pass, err_count, first_err_valid, first_err_addr, first_err_port);
`endif
endinterface

// File: rtl/lutram_dp_array.sv
// lutram_dp_array: D_WIDTH-wide dual-port distributed RAM, async reads on a (spo) and dpra (dpo).
// At A_WIDTH=5 each bit is its own 32x1 dual-port cell so it maps onto one LUTRAM primitive per bit.
module lutram_dp_array #(
   parameter int A_WIDTH = 5,
   parameter int D_WIDTH = 1
) (
   input  logic               wclk,
   input  logic               we,
   input  logic [A_WIDTH-1:0] a,
   input  logic [A_WIDTH-1:0] dpra,
   input  logic [D_WIDTH-1:0] d,
   output logic [D_WIDTH-1:0] spo,
   output logic [D_WIDTH-1:0] dpo
);
   if (A_WIDTH == 5) begin : g_prim
      for (genvar b = 0; b < D_WIDTH; b++) begin : g_bit
         logic [31:0] r_mem;
         always_ff @(posedge wclk)
            if (we) r_mem[a] <= d[b];
         assign spo[b] = r_mem[a];
         assign dpo[b] = r_mem[dpra];
      end
   end else begin : g_inf
      logic [D_WIDTH-1:0] r_mem [2**A_WIDTH];
      always_ff @(posedge wclk)
         if (we) r_mem[a] <= d;
      assign spo = r_mem[a];
      assign dpo = r_mem[dpra];
   end
endmodule

// File: rtl/lutram_bist.sv
// lutram_bist: clear/verify0/write/read self-test of a dual-port LUTRAM, checking SPO and DPO every read cycle.
// Define LUTRAM_BIST_FAULT_INJECT_EN to add bus.fault_inj, which corrupts the word written at address 0.
module lutram_bist
   import lutram_test_pkg::*;
#(
   parameter int A_WIDTH   = 5,
   parameter int D_WIDTH   = 1,
   parameter int ERR_WIDTH = A_WIDTH + 2
) (
   input logic clk,
   input logic rst,
   lutram_bist_if.slave bus
);
   state_t               r_state;
   logic [A_WIDTH-1:0]   r_cnt;
   logic [1:0]           r_mode;
   logic [ERR_WIDTH-1:0] r_err;
   logic                 r_fev;
   logic [A_WIDTH-1:0]   r_fea;
   logic                 r_fep;
   logic                 r_pass;
   logic [A_WIDTH-1:0]   w_ncnt;
   logic                 w_we;
   logic                 w_last;
   logic                 w_rd;
   logic [D_WIDTH-1:0]   w_pat_s;
   logic [D_WIDTH-1:0]   w_pat_d;
   logic [D_WIDTH-1:0]   w_wd;
   logic [D_WIDTH-1:0]   w_spo;
   logic [D_WIDTH-1:0]   w_dpo;
   logic                 w_mis_s;
   logic                 w_mis_d;
   logic [ERR_WIDTH:0]   w_sum;
   logic [ERR_WIDTH-1:0] w_err_next;
   assign w_ncnt  = ~r_cnt;
   assign w_last  = r_cnt == '1;
   assign w_rd    = r_state == READ;
   assign w_we    = r_state == CLEAR || r_state == WRITE;
   assign w_pat_s = D_WIDTH'(pat(r_mode, PAT_W'(r_cnt)));
   assign w_pat_d = D_WIDTH'(pat(r_mode, PAT_W'(w_ncnt)));
`ifdef LUTRAM_BIST_FAULT_INJECT_EN
   assign w_wd = r_state != WRITE ? '0 : (bus.fault_inj && r_cnt == '0) ? ~w_pat_s : w_pat_s;
`else
   assign w_wd = r_state == WRITE ? w_pat_s : '0;
`endif
   lutram_dp_array #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) u_array (
      .wclk (clk),
      .we   (w_we),
      .a    (r_cnt),
      .dpra (w_ncnt),
      .d    (w_wd),
      .spo  (w_spo),
      .dpo  (w_dpo)
   );
   // VERIFY0 expects zeros on both ports; READ expects the pattern of each port's own address.
   assign w_mis_s    = (r_state == VERIFY0 || w_rd) && w_spo != (w_rd ? w_pat_s : '0);
   assign w_mis_d    = (r_state == VERIFY0 || w_rd) && w_dpo != (w_rd ? w_pat_d : '0);
   assign w_sum      = {1'b0, r_err} + (ERR_WIDTH+1)'(w_mis_s) + (ERR_WIDTH+1)'(w_mis_d);
   assign w_err_next = w_sum[ERR_WIDTH] ? '1 : w_sum[ERR_WIDTH-1:0];
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_mode  <= '0;
         r_err   <= '0;
         r_fev   <= 1'b0;
         r_fea   <= '0;
         r_fep   <= 1'b0;
         r_pass  <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (bus.start) begin
                  r_state <= CLEAR;
                  r_cnt   <= '0;
                  r_mode  <= bus.mode;
                  r_err   <= '0;
                  r_fev   <= 1'b0;
                  r_fea   <= '0;
                  r_fep   <= 1'b0;
                  r_pass  <= 1'b0;
               end
            end
            default: begin
               r_cnt <= r_cnt + A_WIDTH'(1);
               r_err <= w_err_next;
               if (w_last)
                  r_state <= r_state == CLEAR ? VERIFY0 : r_state == VERIFY0 ? WRITE : r_state == WRITE ? READ : DONE;
               if (w_last && w_rd)
                  r_pass <= w_err_next == '0;
               // SPO has priority when both ports fail on the first failing cycle.
               if (!r_fev && (w_mis_s || w_mis_d)) begin
                  r_fev <= 1'b1;
                  r_fea <= w_mis_s ? r_cnt : w_ncnt;
                  r_fep <= !w_mis_s;
               end
            end
         endcase
      end
   end
   assign bus.busy            = r_state == CLEAR || r_state == VERIFY0 || r_state == WRITE || r_state == READ;
   assign bus.done            = r_state == DONE;
   assign bus.pass            = r_pass;
   assign bus.err_count       = r_err;
   assign bus.first_err_valid = r_fev;
   assign bus.first_err_addr  = r_fea;
   assign bus.first_err_port  = r_fep;
endmodule

// File: tb/tb_lutram_bist.sv
// tb_lutram_bist: randomized directed checks of lutram_bist against a run-level reference model.
module tb_lutram_bist;
   import lutram_test_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   always #5 clk = ~clk;
   lutram_bist_if #(.A_WIDTH(5), .ERR_WIDTH(7)) bus ();
   lutram_bist_if #(.A_WIDTH(4), .ERR_WIDTH(6)) bus2 ();
   lutram_bist dut (.clk(clk), .rst(rst), .bus(bus));
   lutram_bist #(.A_WIDTH(4), .D_WIDTH(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
   typedef struct {
      int err;
      bit fv;
      int fa;
      bit fp;
   } exp_t;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask
   function automatic logic [63:0] ref_pat(input int m, input int a, input int dw);
      logic [63:0] mask;
      mask = (dw >= 64) ? '1 : (64'd1 << dw) - 64'd1;
      case (m)
         0:       return (a % 2 == 1) ? mask : 64'd0;
         1:       return (a % 2 == 0) ? mask : 64'd0;
         2:       return mask;
         default: return 64'(a) & mask;
      endcase
   endfunction
   // Whole-run outcome: memory contents as a plain array, each read cycle scored from the rules.
   function automatic exp_t model(input int aw, input int dw, input int m, input bit stuck, input bit finj);
      exp_t        r;
      logic [63:0] mem [64];
      logic [63:0] mask;
      logic [63:0] s, d, es, ed;
      int          depth, emax, ms, md;
      depth = 1 << aw;
      emax  = (1 << (aw + 2)) - 1;
      mask  = (dw >= 64) ? '1 : (64'd1 << dw) - 64'd1;
      r     = '{err: 0, fv: 1'b0, fa: 0, fp: 1'b0};
      for (int c = 0; c < depth; c++) mem[c] = 64'd0;
      for (int ph = 0; ph < 2; ph++) begin
         if (ph == 1)
            for (int c = 0; c < depth; c++)
               mem[c] = (finj && c == 0) ? (~ref_pat(m, 0, dw) & mask) : ref_pat(m, c, dw);
         for (int c = 0; c < depth; c++) begin
            s  = mem[c] | (stuck ? 64'd1 : 64'd0);
            d  = mem[depth-1-c];
            es = ph == 1 ? ref_pat(m, c, dw) : 64'd0;
            ed = ph == 1 ? ref_pat(m, depth - 1 - c, dw) : 64'd0;
            ms = (s != es) ? 1 : 0;
            md = (d != ed) ? 1 : 0;
            if (!r.fv && (ms + md) > 0) begin
               r.fv = 1'b1;
               r.fp = (ms == 0);
               r.fa = ms != 0 ? c : depth - 1 - c;
            end
            r.err = (r.err + ms + md > emax) ? emax : r.err + ms + md;
         end
      end
      return r;
   endfunction
   task automatic check_final(input string tag, input exp_t e);
      check({tag, "/done"}, 64'(bus.done), 64'd1);
      check({tag, "/busy"}, 64'(bus.busy), 64'd0);
      check({tag, "/pass"}, 64'(bus.pass), 64'(e.err == 0));
      check({tag, "/err_count"}, 64'(bus.err_count), 64'(e.err));
      check({tag, "/first_err_valid"}, 64'(bus.first_err_valid), 64'(e.fv));
      check({tag, "/first_err_addr"}, 64'(bus.first_err_addr), 64'(e.fa));
      check({tag, "/first_err_port"}, 64'(bus.first_err_port), 64'(e.fp));
   endtask
   task automatic wait_done(input string tag, input bit repulse);
      int cyc, busy_n, rp;
      cyc    = 0;
      busy_n = 0;
      rp     = $urandom_range(1, 126);
      while (!bus.done && cyc < 300) begin
         if (bus.busy) busy_n++;
         bus.mode  = 2'($urandom_range(0, 3));
         bus.start = repulse && cyc == rp;
         @(negedge clk);
         cyc++;
      end
      bus.start = 1'b0;
      check({tag, "/cycles"}, 64'(cyc), 64'd128);
      check({tag, "/busy_cycles"}, 64'(busy_n), 64'd128);
   endtask
   task automatic run1(input int m, input bit stuck, input bit finj, input bit repulse, input string tag);
      exp_t e;
      e = model(5, 1, m, stuck, finj);
      @(negedge clk);
      bus.mode  = 2'(m);
      bus.start = 1'b1;
`ifdef LUTRAM_BIST_FAULT_INJECT_EN
      bus.fault_inj = finj;
`endif
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(tag, repulse);
      check_final(tag, e);
`ifdef LUTRAM_BIST_FAULT_INJECT_EN
      bus.fault_inj = 1'b0;
`endif
   endtask
   task automatic run2(input int m, input string tag);
      int cyc;
      @(negedge clk);
      bus2.mode  = 2'(m);
      bus2.start = 1'b1;
      @(negedge clk);
      bus2.start = 1'b0;
      cyc = 0;
      while (!bus2.done && cyc < 200) begin
         if (cyc >= 48 && cyc < 64) begin
            check({tag, "/spo"}, 64'(dut2.w_spo), ref_pat(m, cyc - 48, 8));
            check({tag, "/dpo"}, 64'(dut2.w_dpo), ref_pat(m, 15 - (cyc - 48), 8));
         end
         bus2.mode = 2'($urandom_range(0, 3));
         @(negedge clk);
         cyc++;
      end
      check({tag, "/cycles"}, 64'(cyc), 64'd64);
      check({tag, "/pass"}, 64'(bus2.pass), 64'd1);
      check({tag, "/err_count"}, 64'(bus2.err_count), 64'd0);
      check({tag, "/first_err_valid"}, 64'(bus2.first_err_valid), 64'd0);
   endtask
   task automatic check_idle(input string tag);
      check({tag, "/state"}, 64'(dut.r_state), 64'(IDLE));
      check({tag, "/cnt"}, 64'(dut.r_cnt), 64'd0);
      check({tag, "/mode_q"}, 64'(dut.r_mode), 64'd0);
      check({tag, "/busy"}, 64'(bus.busy), 64'd0);
      check({tag, "/done"}, 64'(bus.done), 64'd0);
      check({tag, "/pass"}, 64'(bus.pass), 64'd0);
      check({tag, "/err_count"}, 64'(bus.err_count), 64'd0);
      check({tag, "/first_err_valid"}, 64'(bus.first_err_valid), 64'd0);
      check({tag, "/first_err_addr"}, 64'(bus.first_err_addr), 64'd0);
      check({tag, "/first_err_port"}, 64'(bus.first_err_port), 64'd0);
   endtask
   initial begin
      bus.start  = 1'b0;
      bus.mode   = 2'd0;
      bus2.start = 1'b0;
      bus2.mode  = 2'd0;
`ifdef LUTRAM_BIST_FAULT_INJECT_EN
      bus.fault_inj  = 1'b0;
      bus2.fault_inj = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      run1(0, 1'b0, 1'b0, 1'b0, "default_m0");
      for (int i = 0; i < 4; i++) run1(int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b1, "random_run");
      run2(3, "w8_addr");
      run2(int'($urandom_range(0, 3)), "w8_random");
`ifdef LUTRAM_BIST_FAULT_INJECT_EN
      run1(2, 1'b0, 1'b1, 1'b0, "fault_inj");
`endif
      // Restart attempt at cycle 10 must be ignored, then reset lands mid-VERIFY0 at cycle 50.
      @(negedge clk);
      bus.mode  = 2'($urandom_range(1, 3));
      bus.start = 1'b1;
      @(negedge clk);
      for (int c = 0; c < 50; c++) begin
         bus.start = (c == 10);
         @(negedge clk);
      end
      bus.start = 1'b0;
      check("midrun/state", 64'(dut.r_state), 64'(VERIFY0));
      check("midrun/cnt", 64'(dut.r_cnt), 64'd18);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle("midrun_reset");
      run1(int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0, "after_reset");
      force dut.w_spo = 1'b1;
      run1(1, 1'b1, 1'b0, 1'b0, "stuck_spo");
      check("stuck_spo/err48", 64'(bus.err_count), 64'd48);
      release dut.w_spo;
      @(negedge clk);
      bus.mode  = 2'd2;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("restart/done", 64'(bus.done), 64'd0);
      check("restart/busy", 64'(bus.busy), 64'd1);
      check("restart/err_count", 64'(bus.err_count), 64'd0);
      check("restart/first_err_valid", 64'(bus.first_err_valid), 64'd0);
      check("restart/first_err_addr", 64'(bus.first_err_addr), 64'd0);
      check("restart/first_err_port", 64'(bus.first_err_port), 64'd0);
      wait_done("restart", 1'b0);
      check_final("restart", model(5, 1, 2, 1'b0, 1'b0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
